// File: rtl/ex_mem_register.sv
// EX/MEM pipeline register: captures execute-stage results and issues the
// data-memory request to the dcache, holding it until dhit and latching load data.

module ex_mem_register_chk (
  input logic CLK,
  input logic nRST,
  input logic is_halt_MEM,
  input logic mem_busy,
  input logic dmemREN,
  input logic dmemWEN
);

  // A halted op must never reach the dcache.
  a_halt_no_req: assert property (@(posedge CLK) disable iff (!nRST)
    (is_halt_MEM |-> !(dmemREN || dmemWEN)));

  // A stall is only ever raised on behalf of a live request.
  a_busy_has_req: assert property (@(posedge CLK) disable iff (!nRST)
    (mem_busy |-> (dmemREN || dmemWEN)));

endmodule

module ex_mem_register #(
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              pipeline_ctrl,
  input  logic              flush_EX_MEM,
  input  logic [WORD_W-1:0] pc_EX,
  input  logic [WORD_W-1:0] instr_EX,
  input  logic [WORD_W-1:0] alu_out_EX,
  input  logic [WORD_W-1:0] store_EX,
  input  logic [WORD_W-1:0] imm_EX,
  input  logic [4:0]        wsel_EX,
  input  logic              MemWr_EX,
  input  logic              MemRead_EX,
  input  logic              MemtoReg_EX,
  input  logic              RegWr_EX,
  input  logic              is_halt_EX,
  input  logic              datomic_EX,
  input  logic [2:0]        WriteSrc_EX,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  output logic [WORD_W-1:0] pc_MEM,
  output logic [WORD_W-1:0] instr_MEM,
  output logic [WORD_W-1:0] alu_out_MEM,
  output logic [WORD_W-1:0] store_MEM,
  output logic [WORD_W-1:0] imm_MEM,
  output logic [4:0]        wsel_MEM,
  output logic              MemWr_MEM,
  output logic              MemRead_MEM,
  output logic              MemtoReg_MEM,
  output logic              RegWr_MEM,
  output logic              is_halt_MEM,
  output logic              datomic_MEM,
  output logic [2:0]        WriteSrc_MEM,
  output logic [WORD_W-1:0] dload_MEM,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic              dmematomic,
  output logic              mem_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_next_s;

  logic [WORD_W-1:0] pc_r;
  logic [WORD_W-1:0] instr_r;
  logic [WORD_W-1:0] alu_out_r;
  logic [WORD_W-1:0] store_r;
  logic [WORD_W-1:0] imm_r;
  logic [4:0]        wsel_r;
  logic              mem_wr_r;
  logic              mem_read_r;
  logic              mem_to_reg_r;
  logic              reg_wr_r;
  logic              is_halt_r;
  logic              datomic_r;
  logic [2:0]        write_src_r;
  logic [WORD_W-1:0] dload_r;

  logic              capture_s;
  logic              bubble_s;
  logic              issue_s;
  logic              in_req_s;
  logic              load_done_s;

  assign capture_s   = pipeline_ctrl;
  assign bubble_s    = pipeline_ctrl & flush_EX_MEM;
  assign issue_s     = (MemRead_EX | MemWr_EX) & ~is_halt_EX;
  assign in_req_s    = (state_r == REQ);
  assign load_done_s = in_req_s & dhit & mem_read_r;

  // Stage field register: bubble zeroes, advance loads, stall holds.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pc_r         <= {WORD_W{1'b0}};
      instr_r      <= {WORD_W{1'b0}};
      alu_out_r    <= {WORD_W{1'b0}};
      store_r      <= {WORD_W{1'b0}};
      imm_r        <= {WORD_W{1'b0}};
      wsel_r       <= 5'd0;
      mem_wr_r     <= 1'b0;
      mem_read_r   <= 1'b0;
      mem_to_reg_r <= 1'b0;
      reg_wr_r     <= 1'b0;
      is_halt_r    <= 1'b0;
      datomic_r    <= 1'b0;
      write_src_r  <= 3'd0;
    end else if (bubble_s) begin
      pc_r         <= {WORD_W{1'b0}};
      instr_r      <= {WORD_W{1'b0}};
      alu_out_r    <= {WORD_W{1'b0}};
      store_r      <= {WORD_W{1'b0}};
      imm_r        <= {WORD_W{1'b0}};
      wsel_r       <= 5'd0;
      mem_wr_r     <= 1'b0;
      mem_read_r   <= 1'b0;
      mem_to_reg_r <= 1'b0;
      reg_wr_r     <= 1'b0;
      is_halt_r    <= 1'b0;
      datomic_r    <= 1'b0;
      write_src_r  <= 3'd0;
    end else if (capture_s) begin
      pc_r         <= pc_EX;
      instr_r      <= instr_EX;
      alu_out_r    <= alu_out_EX;
      store_r      <= store_EX;
      imm_r        <= imm_EX;
      wsel_r       <= wsel_EX;
      mem_wr_r     <= MemWr_EX;
      mem_read_r   <= MemRead_EX;
      mem_to_reg_r <= MemtoReg_EX;
      reg_wr_r     <= RegWr_EX;
      is_halt_r    <= is_halt_EX;
      datomic_r    <= datomic_EX;
      write_src_r  <= WriteSrc_EX;
    end else begin
      pc_r         <= pc_r;
      instr_r      <= instr_r;
      alu_out_r    <= alu_out_r;
      store_r      <= store_r;
      imm_r        <= imm_r;
      wsel_r       <= wsel_r;
      mem_wr_r     <= mem_wr_r;
      mem_read_r   <= mem_read_r;
      mem_to_reg_r <= mem_to_reg_r;
      reg_wr_r     <= reg_wr_r;
      is_halt_r    <= is_halt_r;
      datomic_r    <= datomic_r;
      write_src_r  <= write_src_r;
    end
  end

  // Load data survives ordinary bubbles; a completing load latches even on an advance edge.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      dload_r <= {WORD_W{1'b0}};
    end else if (bubble_s) begin
      dload_r <= {WORD_W{1'b0}};
    end else if (load_done_s) begin
      dload_r <= dmemload;
    end else begin
      dload_r <= dload_r;
    end
  end

  // Request FSM state register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state: a capture always restarts from the newly captured op.
  always_comb begin
    state_next_s = state_r;
    if (bubble_s) begin
      state_next_s = IDLE;
    end else if (capture_s) begin
      state_next_s = issue_s ? REQ : IDLE;
    end else begin
      case (state_r)
        IDLE:    state_next_s = IDLE;
        REQ:     state_next_s = dhit ? DONE : REQ;
        DONE:    state_next_s = DONE;
        default: state_next_s = IDLE;
      endcase
    end
  end

  assign pc_MEM       = pc_r;
  assign instr_MEM    = instr_r;
  assign alu_out_MEM  = alu_out_r;
  assign store_MEM    = store_r;
  assign imm_MEM      = imm_r;
  assign wsel_MEM     = wsel_r;
  assign MemWr_MEM    = mem_wr_r;
  assign MemRead_MEM  = mem_read_r;
  assign MemtoReg_MEM = mem_to_reg_r;
  assign RegWr_MEM    = reg_wr_r;
  assign is_halt_MEM  = is_halt_r;
  assign datomic_MEM  = datomic_r;
  assign WriteSrc_MEM = write_src_r;
  assign dload_MEM    = dload_r;

  // Strobes are gated by REQ so a held DONE stage cannot issue a second store.
  assign dmemREN    = in_req_s & mem_read_r;
  assign dmemWEN    = in_req_s & mem_wr_r;
  assign dmematomic = in_req_s & datomic_r;
  assign dmemaddr   = alu_out_r;
  assign dmemstore  = store_r;
  assign mem_busy   = in_req_s & ~dhit;

  ex_mem_register_chk u_chk (
    .CLK         (CLK),
    .nRST        (nRST),
    .is_halt_MEM (is_halt_r),
    .mem_busy    (mem_busy),
    .dmemREN     (dmemREN),
    .dmemWEN     (dmemWEN)
  );

endmodule

// File: tb/tb_ex_mem_register.sv
// Directed bench for ex_mem_register with a transaction-level reference model
// compared on every falling clock edge.

module tb_ex_mem_register;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        pipeline_ctrl;
  logic        flush_EX_MEM;
  logic [31:0] pc_EX, instr_EX, alu_out_EX, store_EX, imm_EX;
  logic [4:0]  wsel_EX;
  logic        MemWr_EX, MemRead_EX, MemtoReg_EX, RegWr_EX, is_halt_EX, datomic_EX;
  logic [2:0]  WriteSrc_EX;
  logic        dhit;
  logic [31:0] dmemload;
  logic [31:0] pc_MEM, instr_MEM, alu_out_MEM, store_MEM, imm_MEM;
  logic [4:0]  wsel_MEM;
  logic        MemWr_MEM, MemRead_MEM, MemtoReg_MEM, RegWr_MEM, is_halt_MEM, datomic_MEM;
  logic [2:0]  WriteSrc_MEM;
  logic [31:0] dload_MEM;
  logic        dmemREN, dmemWEN;
  logic [31:0] dmemaddr, dmemstore;
  logic        dmematomic, mem_busy;

  logic auto_pc;
  logic pc_drv;
  assign pipeline_ctrl = auto_pc ? ~mem_busy : pc_drv;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  ex_mem_register #(.WORD_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .pipeline_ctrl(pipeline_ctrl), .flush_EX_MEM(flush_EX_MEM),
    .pc_EX(pc_EX), .instr_EX(instr_EX), .alu_out_EX(alu_out_EX), .store_EX(store_EX),
    .imm_EX(imm_EX), .wsel_EX(wsel_EX), .MemWr_EX(MemWr_EX), .MemRead_EX(MemRead_EX),
    .MemtoReg_EX(MemtoReg_EX), .RegWr_EX(RegWr_EX), .is_halt_EX(is_halt_EX),
    .datomic_EX(datomic_EX), .WriteSrc_EX(WriteSrc_EX), .dhit(dhit), .dmemload(dmemload),
    .pc_MEM(pc_MEM), .instr_MEM(instr_MEM), .alu_out_MEM(alu_out_MEM), .store_MEM(store_MEM),
    .imm_MEM(imm_MEM), .wsel_MEM(wsel_MEM), .MemWr_MEM(MemWr_MEM), .MemRead_MEM(MemRead_MEM),
    .MemtoReg_MEM(MemtoReg_MEM), .RegWr_MEM(RegWr_MEM), .is_halt_MEM(is_halt_MEM),
    .datomic_MEM(datomic_MEM), .WriteSrc_MEM(WriteSrc_MEM), .dload_MEM(dload_MEM),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .dmematomic(dmematomic), .mem_busy(mem_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the stage holds one op; it owes the dcache a request until dhit.
  typedef struct packed {
    logic [31:0] pc, instr, alu, store, imm;
    logic [4:0]  wsel;
    logic        wr, rd, m2r, rw, halt, atomic;
    logic [2:0]  wsrc;
  } op_t;

  op_t         m_op;
  logic        m_pending;
  logic [31:0] m_dload;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_op      <= '0;
      m_pending <= 1'b0;
      m_dload   <= 32'd0;
    end else if (pipeline_ctrl && flush_EX_MEM) begin
      m_op      <= '0;
      m_pending <= 1'b0;
      m_dload   <= 32'd0;
    end else if (pipeline_ctrl) begin
      m_op      <= '{pc_EX, instr_EX, alu_out_EX, store_EX, imm_EX, wsel_EX, MemWr_EX,
                    MemRead_EX, MemtoReg_EX, RegWr_EX, is_halt_EX, datomic_EX, WriteSrc_EX};
      m_pending <= (MemRead_EX || MemWr_EX) && !is_halt_EX;
      if (m_pending && dhit && m_op.rd) m_dload <= dmemload;
    end else if (m_pending && dhit) begin
      m_pending <= 1'b0;
      if (m_op.rd) m_dload <= dmemload;
    end
  end

  always @(negedge CLK) begin
    chk("pc",       pc_MEM,                m_op.pc);
    chk("instr",    instr_MEM,             m_op.instr);
    chk("alu_out",  alu_out_MEM,           m_op.alu);
    chk("store",    store_MEM,             m_op.store);
    chk("imm",      imm_MEM,               m_op.imm);
    chk("wsel",     32'(wsel_MEM),         32'(m_op.wsel));
    chk("ctl",      32'({MemWr_MEM, MemRead_MEM, MemtoReg_MEM, RegWr_MEM, is_halt_MEM, datomic_MEM}),
                    32'({m_op.wr, m_op.rd, m_op.m2r, m_op.rw, m_op.halt, m_op.atomic}));
    chk("wsrc",     32'(WriteSrc_MEM),     32'(m_op.wsrc));
    chk("dload",    dload_MEM,             m_dload);
    chk("dmemREN",  32'(dmemREN),          32'(m_pending && m_op.rd));
    chk("dmemWEN",  32'(dmemWEN),          32'(m_pending && m_op.wr));
    chk("atomic",   32'(dmematomic),       32'(m_pending && m_op.atomic));
    chk("busy",     32'(mem_busy),         32'(m_pending && !dhit));
    chk("addr",     dmemaddr,              m_op.alu);
    chk("stdata",   dmemstore,             m_op.store);
  end

  task automatic set_ex(input logic rd, input logic wr, input logic at, input logic halt,
                        input logic [31:0] alu, input logic [31:0] st, input logic [31:0] pc);
    MemRead_EX  = rd;
    MemWr_EX    = wr;
    datomic_EX  = at;
    is_halt_EX  = halt;
    alu_out_EX  = alu;
    store_EX    = st;
    pc_EX       = pc;
    instr_EX    = {pc[15:0], alu[15:0]};
    imm_EX      = alu + 32'd4;
    wsel_EX     = pc[6:2];
    MemtoReg_EX = rd;
    RegWr_EX    = rd;
    WriteSrc_EX = {halt, rd, wr};
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    nRST = 1'b0; auto_pc = 1'b0; pc_drv = 1'b1; flush_EX_MEM = 1'b0;
    dhit = 1'b0; dmemload = 32'd0;
    set_ex(1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0);

    // Reset held with an active load waiting at the input.
    tick; tick;
    @(negedge CLK);
    chk("rst_ren", 32'(dmemREN), 32'd0);
    chk("rst_alu", alu_out_MEM, 32'd0);
    chk("rst_busy", 32'(mem_busy), 32'd0);
    tick; nRST = 1'b1;
    tick;
    @(negedge CLK);
    chk("first_ren", 32'(dmemREN), 32'd1);
    chk("first_addr", dmemaddr, 32'h40);
    pc_drv = 1'b0; dhit = 1'b1; dmemload = 32'h11;
    tick; dhit = 1'b0;
    @(negedge CLK);
    chk("first_dload", dload_MEM, 32'h11);
    chk("first_done_ren", 32'(dmemREN), 32'd0);

    // LW with dhit after three busy cycles, pipeline advancing on !mem_busy.
    set_ex(1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 32'h1000);
    pc_drv = 1'b1;
    tick;
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h1004);
    auto_pc = 1'b1;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      if (mem_busy) cnt++;
      tick;
    end
    chk("lw_busy_cycles", 32'(cnt), 32'd3);
    dhit = 1'b1; dmemload = 32'hDEADBEEF;
    @(negedge CLK);
    chk("lw_busy_dhit", 32'(mem_busy), 32'd0);
    chk("lw_ren_dhit", 32'(dmemREN), 32'd1);
    tick; dhit = 1'b0; auto_pc = 1'b0; pc_drv = 1'b0;
    @(negedge CLK);
    chk("lw_dload", dload_MEM, 32'hDEADBEEF);
    chk("lw_ren_after", 32'(dmemREN), 32'd0);

    // SW completing on its second cycle, then held for two more cycles.
    set_ex(1'b0, 1'b1, 1'b0, 1'b0, 32'h200, 32'h12345678, 32'h1008);
    pc_drv = 1'b1;
    tick; pc_drv = 1'b0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      dhit = (i == 1);
      @(negedge CLK);
      if (i == 0) chk("sw_store", dmemstore, 32'h12345678);
      if (dmemWEN) cnt++;
      tick;
    end
    dhit = 1'b0;
    chk("sw_wen_cycles", 32'(cnt), 32'd2);

    // Flush is ignored while stalled, honoured on the advance edge.
    set_ex(1'b1, 1'b0, 1'b0, 1'b0, 32'h300, 32'h0, 32'h100C);
    flush_EX_MEM = 1'b1;
    tick;
    @(negedge CLK);
    chk("flush_hold_alu", alu_out_MEM, 32'h200);
    pc_drv = 1'b1;
    tick; pc_drv = 1'b0; flush_EX_MEM = 1'b0;
    @(negedge CLK);
    chk("flush_alu", alu_out_MEM, 32'd0);
    chk("flush_dload", dload_MEM, 32'd0);
    chk("flush_ren", 32'(dmemREN), 32'd0);

    // Back-to-back LW then SW, each hit on its first cycle.
    set_ex(1'b1, 1'b0, 1'b0, 1'b0, 32'h400, 32'h0, 32'h1010);
    pc_drv = 1'b1;
    tick;
    set_ex(1'b0, 1'b1, 1'b0, 1'b0, 32'h500, 32'hCAFEF00D, 32'h1014);
    dhit = 1'b1; dmemload = 32'h0BADF00D;
    @(negedge CLK);
    chk("b2b_lw_busy", 32'(mem_busy), 32'd0);
    tick; dhit = 1'b0;
    @(negedge CLK);
    chk("b2b_sw_wen", 32'(dmemWEN), 32'd1);
    chk("b2b_sw_addr", dmemaddr, 32'h500);
    chk("b2b_lw_dload", dload_MEM, 32'h0BADF00D);
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h1018);
    dhit = 1'b1;
    tick; dhit = 1'b0;
    @(negedge CLK);
    chk("b2b_wen_after", 32'(dmemWEN), 32'd0);
    chk("b2b_dload_kept", dload_MEM, 32'h0BADF00D);

    // A halted load never requests.
    set_ex(1'b1, 1'b0, 1'b0, 1'b1, 32'h700, 32'h0, 32'h101C);
    tick;
    @(negedge CLK);
    chk("halt_ren", 32'(dmemREN), 32'd0);
    chk("halt_flag", 32'(is_halt_MEM), 32'd1);

    // LR followed by reset in the middle of the request.
    set_ex(1'b1, 1'b0, 1'b1, 1'b0, 32'h600, 32'h0, 32'h1020);
    tick; pc_drv = 1'b0;
    @(negedge CLK);
    chk("lr_atomic", 32'(dmematomic), 32'd1);
    chk("lr_ren", 32'(dmemREN), 32'd1);
    #2; nRST = 1'b0;
    #1;
    chk("lr_rst_atomic", 32'(dmematomic), 32'd0);
    chk("lr_rst_ren", 32'(dmemREN), 32'd0);
    chk("lr_rst_busy", 32'(mem_busy), 32'd0);
    tick; nRST = 1'b1;
    @(negedge CLK);
    chk("post_rst_ren", 32'(dmemREN), 32'd0);
    chk("post_rst_busy", 32'(mem_busy), 32'd0);
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mem_register.md
Name: ex_mem_register

Overview:
- Pipeline register between the execute stage and the memory stage of each core.
- Captures EX results and control fields, then issues the data-memory request to the dcache.
- Holds the request until dhit and latches the load data for the MEM/WB register.
- Drives mem_busy to the hazard unit, which folds it into pipeline_ctrl.

Parameters:
- WORD_W, 32, datapath word width (matches word_t).

Ports:
- CLK  input  1  clock
- nRST  input  1  asynchronous active-low reset
- pipeline_ctrl  input  1  global advance enable from hazard unit
- flush_EX_MEM  input  1  bubble insert; honoured only when pipeline_ctrl=1
- pc_EX, instr_EX  input  32  EX-stage PC / instruction
- alu_out_EX  input  32  ALU result / effective address
- store_EX  input  32  forwarded rs2 data
- imm_EX  input  32  immediate
- wsel_EX  input  5  destination register
- MemWr_EX, MemRead_EX, MemtoReg_EX, RegWr_EX, is_halt_EX, datomic_EX  input  1 each  control
- WriteSrc_EX  input  3  writeback mux select
- dhit  input  1  dcache completion strobe
- dmemload  input  32  dcache read data
- pc_MEM, instr_MEM, alu_out_MEM, store_MEM, imm_MEM  output  32  registered copies
- wsel_MEM  output  5
- MemWr_MEM, MemRead_MEM, MemtoReg_MEM, RegWr_MEM, is_halt_MEM, datomic_MEM  output  1 each
- WriteSrc_MEM  output  3
- dload_MEM  output  32  latched load data
- dmemREN, dmemWEN  output  1  dcache request strobes
- dmemaddr, dmemstore  output  32  request address / store data
- dmematomic  output  1  LR/SC qualifier to dcache
- mem_busy  output  1  request outstanding, stall pipeline

Behaviour:
- Reset (async, nRST=0): all *_MEM outputs and dload_MEM = 0; FSM = IDLE; dmemREN = dmemWEN = dmematomic = 0; mem_busy = 0. Reset mid-request drops the strobes immediately.
- Capture at posedge:
  - If pipeline_ctrl=1 and flush_EX_MEM=0: load all EX fields.
  - If pipeline_ctrl=1 and flush_EX_MEM=1: load all fields with zeros; FSM goes to IDLE.
  - If pipeline_ctrl=0: hold all fields, whatever flush_EX_MEM is.
- Capture latency is one cycle.
- FSM states:
  - IDLE: no request pending.
  - REQ: request issued, waiting for dhit.
  - DONE: request completed, result held.
- Next-state on capture (takes priority over other transitions): REQ if the captured op has (MemRead_EX | MemWr_EX) and !is_halt_EX; otherwise IDLE.
- Without capture:
  - REQ with dhit=1 goes to DONE and latches dload_MEM <= dmemload (loads only; stores leave dload_MEM unchanged).
  - REQ with dhit=0 holds.
  - IDLE and DONE hold.
- Simultaneous dhit and capture in REQ: dload_MEM latches dmemload and the new op is captured on the same edge. The next state is taken from the new op.
- Outputs (combinational from state/registers):
  - dmemREN = (state==REQ) & MemRead_MEM
  - dmemWEN = (state==REQ) & MemWr_MEM
  - dmematomic = (state==REQ) & datomic_MEM
  - dmemaddr = alu_out_MEM; dmemstore = store_MEM
  - mem_busy = (state==REQ) & !dhit. It falls in the dhit cycle so the pipeline can advance on that edge.
- Strobes stay stable and never re-pulse while in REQ. In DONE, strobes are 0 so a held stage never double-issues a store.
- Halt: an op with is_halt_MEM=1 never requests.
- Flushed bubble: all controls are 0, so no request.
- dload_MEM is zeroed only by reset or flush; bubbles otherwise leave it unchanged.

Test Plan:
- Reset with pipeline_ctrl=1 and MemRead_EX=1 held -> all outputs 0 while nRST=0. First edge after release captures the op; dmemREN=1, dmemaddr=alu_out_EX.
- LW at addr 0x100, dhit after 3 cycles with dmemload=0xDEADBEEF, pipeline_ctrl=!mem_busy -> mem_busy=1 for 3 cycles, 0 in the dhit cycle. dload_MEM=0xDEADBEEF next cycle; dmemREN=0 in DONE.
- SW addr 0x200 data 0x12345678, dhit on the 2nd cycle, pipeline_ctrl held 0 two more cycles -> dmemWEN high exactly 2 cycles, then 0 while held. No second write.
- flush_EX_MEM=1 with pipeline_ctrl=0, then with pipeline_ctrl=1, incoming LW -> first edge holds old fields. Second edge zeroes all fields; no dmemREN.
- Back-to-back LW then SW, dhit on the first cycle of each -> LW load latched and SW captured on the same edge. dmemWEN asserts the next cycle with SW's address; no stall bubble.
- LR with datomic_EX=1, then nRST pulsed low mid-REQ -> dmematomic=1 and dmemREN=1 before reset; both 0 asynchronously on nRST fall; FSM IDLE after release.
